// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption round controller.
// One plaintext block is accepted over valid/ready. The initial AddRoundKey
// runs on the accept edge, and each following clock executes one round
// through a single shared SubBytes/ShiftRows/MixColumns/AddRoundKey
// datapath. The ciphertext is held in the state register until it is
// consumed. Byte n of every 128-bit vector is bits [8n +: 8], and column c
// is bytes 4c..4c+3.
module aes_round_ctrl #(
   parameter int NR = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [0:127]  data_in,
   input  logic [0:1407] round_keys,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [0:127]  data_out,
   output logic          busy
);

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   // Forward S-box. Entry x sits at bits [8x +: 8].
   localparam logic [0:2047] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       r_fsm;
   state_t       w_fsm_next;
   logic [3:0]   r_round;
   logic [3:0]   w_round_next;
   logic [0:127] r_state;
   logic [0:127] w_state_next;
   logic         r_out_valid;
   logic [0:127] w_round_key;
   logic [0:127] w_shifted;
   logic [0:127] w_mixed;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[{x, 3'b000} +: 8];
   endfunction

   function automatic logic [0:127] sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      for (int n = 0; n < 16; n++) o[8*n +: 8] = sbox(s[8*n +: 8]);
      return o;
   endfunction

   // Row r of column c takes the byte from column (c + r) mod 4.
   function automatic logic [0:127] shift_rows(input logic [0:127] s);
      logic [0:127] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      return o;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [0:127] mix_columns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c      +: 8];
         a1 = s[32*c + 8  +: 8];
         a2 = s[32*c + 16 +: 8];
         a3 = s[32*c + 24 +: 8];
         o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // Shared round datapath; the key for the round currently executing is read live.
   assign w_round_key = round_keys[{r_round, 7'd0} +: 128];
   assign w_shifted   = shift_rows(sub_bytes(r_state));
   assign w_mixed     = mix_columns(w_shifted);

   // Next-state, round counter and state-register update for the controller.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
      w_fsm_next   = r_fsm;
      w_round_next = r_round;
      w_state_next = r_state;
      case (r_fsm)
         S_IDLE: begin
            if (in_valid) begin
               w_state_next = data_in ^ round_keys[0:127];
               w_round_next = 4'd1;
               w_fsm_next   = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_round == 4'd0 || r_round > LAST_ROUND) begin
               // Corrupted counter: abandon the block without presenting it.
               w_fsm_next   = S_IDLE;
               w_round_next = 4'd0;
            end else if (r_round == LAST_ROUND) begin
               w_state_next = w_shifted ^ w_round_key;
               w_fsm_next   = S_DONE;
            end else begin
               w_state_next = w_mixed ^ w_round_key;
               w_round_next = r_round + 4'd1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_fsm_next   = S_IDLE;
               w_round_next = 4'd0;
            end
         end
         default: begin
            w_fsm_next   = S_IDLE;
            w_round_next = 4'd0;
         end
      endcase
   end

   // State register: FSM, round counter, cipher state and registered out_valid.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_fsm       <= S_IDLE;
         r_round     <= 4'd0;
         // NOTE: the wide state register is reset on purpose so an aborted block never leaves partial ciphertext on data_out.
         r_state     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_fsm       <= w_fsm_next;
         r_round     <= w_round_next;
         r_state     <= w_state_next;
         r_out_valid <= (w_fsm_next == S_DONE);
      end
   end

   assign in_ready  = (r_fsm == S_IDLE) && !rst;
   assign busy      = (r_fsm == S_BUSY) || (r_fsm == S_DONE);
   assign out_valid = r_out_valid;
   assign data_out  = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: the stimulus side pushes expected
// ciphertext and accept cycles; a monitor pops and compares on each
// out_valid/out_ready handshake. The reference model is a byte-matrix AES
// with an S-box derived from the GF(2^8) inverse and the affine map.
module tb_aes_round_ctrl;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [0:127]  data_in;
   logic [0:1407] round_keys;
   logic          out_valid;
   logic          out_ready;
   logic [0:127]  data_out;
   logic          busy;

   aes_round_ctrl #(.NR(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_in    (data_in),
      .round_keys (round_keys),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic [0:127] exp_q[$];
   int           acc_q[$];
   logic [7:0]   sbox_tab[256];

   int accept_cnt = 0;
   int busy_cnt   = 0;
   int stall_cnt  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: actual timeout required DUT event", name);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [0:1407] expand_key(input logic [0:127] key);
      logic [31:0]   w[44];
      logic [31:0]   t;
      logic [7:0]    rcon = 8'h01;
      logic [0:1407] o;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) o[32*i +: 32] = w[i];
      return o;
   endfunction

   function automatic logic [0:127] aes_model(input logic [0:127] pt, input logic [0:1407] rk);
      logic [7:0]   s[4][4];
      logic [7:0]   t[4][4];
      logic [0:127] k;
      logic [0:127] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[8*(4*c+r) +: 8] ^ rk[8*(4*c+r) +: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         k = rk[128*rnd +: 128];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sbox_tab[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
               s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ k[8*(4*c+r) +: 8];
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = s[r][c];
      return o;
   endfunction

   task automatic rand128(output logic [0:127] v);
      for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom();
   endtask

   task automatic rand_keys(output logic [0:1407] v);
      for (int i = 0; i < 44; i++) v[32*i +: 32] = $urandom();
   endtask

   // ---------------- driver helpers ----------------
   task automatic send(input logic [0:127] pt, input logic [0:1407] rk,
                       input logic [0:127] expv, output int acc_cyc);
      int n = 0;
      acc_cyc = -1;
      @(negedge clk);
      data_in    = pt;
      round_keys = rk;
      in_valid   = 1'b1;
      while (n < 60) begin
         #1;
         if (in_ready) break;
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         timeout_fail("accept_timeout");
         in_valid = 1'b0;
      end else begin
         acc_cyc = cyc + 1;
         exp_q.push_back(expv);
         acc_q.push_back(acc_cyc);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) timeout_fail("idle_timeout");
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic         prev_valid = 1'b0;
      logic [0:127] prev_data  = '0;
      int           t;
      logic [0:127] e;
      forever begin
         @(negedge clk);
         #1;
         if (in_valid && in_ready) accept_cnt++;
         if (busy) busy_cnt++;
         if (out_valid && !out_ready) stall_cnt++;
         if (out_valid && !prev_valid) begin
            if (acc_q.size() > 0) begin
               t = acc_q.pop_front();
               check("latency", cyc - t, 10);
            end else begin
               check("unexpected_out_valid", out_valid, 1'b0);
            end
         end
         if (out_valid && prev_valid) begin
            check("data_out_hold", data_out, prev_data);
            check("in_ready_in_done", in_ready, 1'b0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("ciphertext", data_out, e);
            end else begin
               check("unexpected_result", out_valid, 1'b0);
            end
         end
         prev_valid = out_valid;
         prev_data  = data_out;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [0:127]  pt, pt2, key, ct, ones;
      logic [0:1407] rk;
      int            a0, a1, a2, acc;
      int            b_acc, b_busy, b_stall, n;

      build_sbox();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; round_keys = '0;

      // Reset state.
      @(negedge clk); #1;
      check("in_ready_during_rst", in_ready, 1'b0);
      @(negedge clk); #1;
      check("rst_busy", busy, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_data_out", data_out, 128'h0);
      check("rst_round", dut.r_round, 4'd0);
      check("in_ready_rst_high", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", in_ready, 1'b1);

      // FIPS-197 App. B.
      pt  = 128'h3243f6a8885a308d313198a2e0370734;
      key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      ct  = 128'h3925841d02dc09fbdc118597196a0b32;
      rk  = expand_key(key);
      out_ready = 1'b1;
      send(pt, rk, ct, acc);
      wait_idle();

      // FIPS-197 App. C.1, three blocks back to back.
      pt  = 128'h00112233445566778899aabbccddeeff;
      key = 128'h000102030405060708090a0b0c0d0e0f;
      ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      rk  = expand_key(key);
      send(pt, rk, ct, a0);
      send(pt, rk, ct, a1);
      send(pt, rk, ct, a2);
      check("throughput_1", a1 - a0, 12);
      check("throughput_2", a2 - a1, 12);
      wait_idle();

      // Back-pressure: 20 stall cycles with an ignored in_valid pulse.
      out_ready = 1'b0;
      rand128(pt);
      rand_keys(rk);
      send(pt, rk, aes_model(pt, rk), acc);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout_fail("out_valid_timeout");
      b_acc = accept_cnt;
      pt2 = ~pt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = (i == 5);
         data_in  = pt2;
      end
      in_valid = 1'b0;
      #1;
      check("bp_no_accept", accept_cnt - b_acc, 0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check("bp_release_in_ready", in_ready, 1'b1);
      check("bp_release_busy", busy, 1'b0);
      check("bp_queue_drained", exp_q.size(), 0);

      // Reset in round 5, then a fresh App. B block.
      pt  = 128'h3243f6a8885a308d313198a2e0370734;
      key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      ct  = 128'h3925841d02dc09fbdc118597196a0b32;
      rk  = expand_key(key);
      out_ready = 1'b1;
      send(pt, rk, ct, acc);
      repeat (4) @(negedge clk);
      check("abort_at_round5", dut.r_round, 4'd5);
      void'(exp_q.pop_back());
      void'(acc_q.pop_back());
      rst = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_data_out", data_out, 128'h0);
      send(pt, rk, ct, acc);
      wait_idle();

      // Random blocks with in_valid/out_ready toggling while busy.
      for (int blk = 0; blk < 6; blk++) begin
         rand128(pt);
         rand_keys(rk);
         out_ready = 1'b0;
         b_acc = accept_cnt; b_busy = busy_cnt; b_stall = stall_cnt;
         send(pt, rk, aes_model(pt, rk), acc);
         n = 0;
         while (n < 120) begin
            if (!busy && exp_q.size() == 0) break;
            in_valid = ($urandom_range(0, 1) == 1);
            rand128(pt2);
            data_in = pt2;
            out_ready = out_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 1);
            @(negedge clk);
            n++;
         end
         in_valid  = 1'b0;
         out_ready = 1'b0;
         if (n >= 120) timeout_fail("random_block_timeout");
         #1;
         check("one_accept_per_block", accept_cnt - b_acc, 1);
         check("busy_cycles", busy_cnt - b_busy, 11 + (stall_cnt - b_stall));
      end

      // Round 0: zero plaintext with all-ones rk0.
      pt   = '0;
      ones = '1;
      rand_keys(rk);
      rk[0:127] = ones;
      out_ready = 1'b1;
      send(pt, rk, aes_model(pt, rk), acc);
      check("round0_state", dut.r_state, ones);
      wait_idle();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual still running required finished");
      $fatal(1, "watchdog expired");
   end

endmodule
